// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg
// Shared types and encodings for the pipelined datapath.
//   word_t / regbits_t : datapath word and register-select types
//   mem_state_t        : memory-stage sequencing states
//   WB_*               : write-back source select (memtoreg)
//   PC_*               : next-PC source select (pcsrc)
package cpu_types_pkg;

    typedef logic [31:0] word_t;
    typedef logic [4:0]  regbits_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,   // ready for a new instruction / issuing a request
        WAIT = 2'd1,   // request outstanding, holding it on the bus
        DONE = 2'd2,   // request completed while downstream was holding
        HALT = 2'd3    // halted; only reset leaves this state
    } mem_state_t;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;
    localparam logic [1:0] WB_IMM = 2'b11;

    localparam logic [1:0] PC_SEQ = 2'b00;
    localparam logic [1:0] PC_BR  = 2'b01;
    localparam logic [1:0] PC_J   = 2'b10;
    localparam logic [1:0] PC_JR  = 2'b11;

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// mem_stage_ctrl_if
// Data-cache request/response bus between the memory stage and the cache.
//   dmemREN/dmemWEN : read / write strobes        (memory stage -> cache)
//   dmemaddr        : word address                (memory stage -> cache)
//   dmemstore       : store data                  (memory stage -> cache)
//   dhit            : current request completed   (cache -> memory stage)
//   dmemload        : load data, valid with dhit  (cache -> memory stage)
interface mem_stage_ctrl_if #(
    parameter int WORD_W = 32
);
    logic              dmemREN;
    logic              dmemWEN;
    logic [WORD_W-1:0] dmemaddr;
    logic [WORD_W-1:0] dmemstore;
    logic              dhit;
    logic [WORD_W-1:0] dmemload;

    modport master (
        output dmemREN, dmemWEN, dmemaddr, dmemstore,
        input  dhit, dmemload
    );

    modport slave (
        input  dmemREN, dmemWEN, dmemaddr, dmemstore,
        output dhit, dmemload
    );
endinterface

// File: rtl/mem_stage_ctrl_npc_resolve.sv
// npc_resolve
// Combinational redirect resolution for branches and jumps.
//   en       : the instruction is advancing this cycle (one redirect per instr)
//   pcsrc    : next-PC select; zero: branch condition
//   baddr / jaddr / aluout : branch, jump and register-jump targets
//   redirect : take npc this cycle; npc is 0 when not redirecting
module npc_resolve #(
    parameter int WORD_W = 32
) (
    input  logic              en,
    input  logic [1:0]        pcsrc,
    input  logic              zero,
    input  logic [WORD_W-1:0] baddr,
    input  logic [WORD_W-1:0] jaddr,
    input  logic [WORD_W-1:0] aluout,
    output logic              redirect,
    output logic [WORD_W-1:0] npc
);
    import cpu_types_pkg::*;

    always_comb begin
        redirect = 1'b0;
        npc      = '0;
        if (en) begin
            case (pcsrc)
                PC_BR: begin
                    if (zero) begin
                        redirect = 1'b1;
                        npc      = baddr;
                    end
                end
                PC_J: begin
                    redirect = 1'b1;
                    npc      = jaddr;
                end
                PC_JR: begin
                    redirect = 1'b1;
                    npc      = aluout;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl
// Memory-stage controller at the output of the EX/MEM latch.
//   CLK, nRST          : clock, asynchronous active-low reset
//   ex_*               : registered EX/MEM latch fields
//   ext_stall          : downstream (MEM/WB) cannot accept this cycle
//   dbus               : data-cache request/response bus (master side)
//   exmem_en           : EX/MEM latch advance enable
//   pipe_flush/npc_sel : redirect this cycle to npc (flushes younger stages)
//   wb_*               : registered write-back bundle
//   halt               : sticky halt, set when a halting instruction advances
module mem_stage_ctrl #(
    parameter int WORD_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              ex_valid,
    input  logic [WORD_W-1:0] ex_aluout,
    input  logic [WORD_W-1:0] ex_rdat2,
    input  logic [WORD_W-1:0] ex_imm,
    input  logic [WORD_W-1:0] ex_pc4,
    input  logic [WORD_W-1:0] ex_jaddr,
    input  logic [WORD_W-1:0] ex_baddr,
    input  logic [REG_W-1:0]  ex_wsel,
    input  logic              ex_regwr,
    input  logic              ex_dren,
    input  logic              ex_dwen,
    input  logic              ex_zero,
    input  logic              ex_halt,
    input  logic [1:0]        ex_memtoreg,
    input  logic [1:0]        ex_pcsrc,
    input  logic              ext_stall,
    mem_stage_ctrl_if.master  dbus,
    output logic              exmem_en,
    output logic              pipe_flush,
    output logic              npc_sel,
    output logic [WORD_W-1:0] npc,
    output logic              wb_valid,
    output logic              wb_regwr,
    output logic [REG_W-1:0]  wb_wsel,
    output logic [WORD_W-1:0] wb_wdat,
    output logic              halt
);
    import cpu_types_pkg::*;

    mem_state_t        state_reg, state_next;
    logic [WORD_W-1:0] ld_buf_reg;
    logic [WORD_W-1:0] ld_data;
    logic [WORD_W-1:0] wdat_next;
    logic              mem_op, mem_phase, req, advance, capture, redirect;

    // nRST is folded into mem_op/advance so every combinational output is
    // forced low while reset is held, independent of the latch contents.
    always_comb begin
        mem_op    = nRST & ex_valid & (ex_dren | ex_dwen);
        mem_phase = (state_reg == IDLE) || (state_reg == WAIT);
        req       = mem_op & mem_phase;
        advance   = nRST & ex_valid & !ext_stall & (state_reg != HALT) &
                    (!mem_op | (mem_phase & dbus.dhit) | (state_reg == DONE));
        // Hit arrived but downstream is holding: keep the data for later.
        capture   = req & dbus.dhit & ext_stall;
        exmem_en  = nRST & !ext_stall & !(mem_op & !advance) & (state_reg != HALT);

        // The latch is frozen while WAIT, so the request naturally repeats
        // with identical values. Read wins over an (illegal) read+write.
        dbus.dmemREN   = req & ex_dren;
        dbus.dmemWEN   = req & ex_dwen & !ex_dren;
        dbus.dmemaddr  = req ? ex_aluout : '0;
        dbus.dmemstore = req ? ex_rdat2  : '0;

        ld_data = dbus.dhit ? dbus.dmemload : ld_buf_reg;
        case (ex_memtoreg)
            WB_ALU:  wdat_next = ex_aluout;
            WB_MEM:  wdat_next = ld_data;
            WB_PC4:  wdat_next = ex_pc4;
            default: wdat_next = ex_imm;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (mem_op) begin
                    if (!dbus.dhit)    state_next = WAIT;
                    else if (ext_stall) state_next = DONE;
                end
            end
            WAIT: begin
                if (dbus.dhit) state_next = ext_stall ? DONE : IDLE;
            end
            DONE: begin
                if (!ext_stall) state_next = IDLE;
            end
            default: state_next = HALT;
        endcase
        if (advance & ex_halt) state_next = HALT;
    end

    npc_resolve #(.WORD_W(WORD_W)) u_npc_resolve (
        .en       (advance),
        .pcsrc    (ex_pcsrc),
        .zero     (ex_zero),
        .baddr    (ex_baddr),
        .jaddr    (ex_jaddr),
        .aluout   (ex_aluout),
        .redirect (redirect),
        .npc      (npc)
    );

    assign npc_sel    = redirect;
    assign pipe_flush = redirect;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_reg  <= IDLE;
            ld_buf_reg <= '0;
            wb_valid   <= 1'b0;
            wb_regwr   <= 1'b0;
            wb_wsel    <= '0;
            wb_wdat    <= '0;
            halt       <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (capture) ld_buf_reg <= dbus.dmemload;
            if (advance & ex_halt) halt <= 1'b1;
            if (!ext_stall) begin
                wb_valid <= advance & !ex_halt;
                wb_regwr <= advance & ex_regwr & !ex_halt;
                wb_wsel  <= ex_wsel;
                wb_wdat  <= wdat_next;
            end
        end
    end
endmodule

// File: tb/tb_mem_stage_ctrl.sv
module tb_mem_stage_ctrl;
    import cpu_types_pkg::*;

    logic CLK = 1'b0;
    logic nRST = 1'b0;
    always #5 CLK = ~CLK;

    logic        ex_valid, ex_regwr, ex_dren, ex_dwen, ex_zero, ex_halt, ext_stall;
    logic [31:0] ex_aluout, ex_rdat2, ex_imm, ex_pc4, ex_jaddr, ex_baddr;
    logic [4:0]  ex_wsel;
    logic [1:0]  ex_memtoreg, ex_pcsrc;
    logic        exmem_en, pipe_flush, npc_sel, wb_valid, wb_regwr, halt;
    logic [31:0] npc, wb_wdat;
    logic [4:0]  wb_wsel;

    mem_stage_ctrl_if #(.WORD_W(32)) dbus ();

    mem_stage_ctrl #(.WORD_W(32), .REG_W(5)) dut (
        .CLK(CLK), .nRST(nRST), .ex_valid(ex_valid), .ex_aluout(ex_aluout),
        .ex_rdat2(ex_rdat2), .ex_imm(ex_imm), .ex_pc4(ex_pc4), .ex_jaddr(ex_jaddr),
        .ex_baddr(ex_baddr), .ex_wsel(ex_wsel), .ex_regwr(ex_regwr), .ex_dren(ex_dren),
        .ex_dwen(ex_dwen), .ex_zero(ex_zero), .ex_halt(ex_halt), .ex_memtoreg(ex_memtoreg),
        .ex_pcsrc(ex_pcsrc), .ext_stall(ext_stall), .dbus(dbus), .exmem_en(exmem_en),
        .pipe_flush(pipe_flush), .npc_sel(npc_sel), .npc(npc), .wb_valid(wb_valid),
        .wb_regwr(wb_regwr), .wb_wsel(wb_wsel), .wb_wdat(wb_wdat), .halt(halt)
    );

    typedef struct {
        bit valid, regwr, dren, dwen, zero, hlt;
        logic [31:0] aluout, rdat2, imm, pc4, jaddr, baddr;
        logic [4:0]  wsel;
        logic [1:0]  memtoreg, pcsrc;
    } instr_t;

    typedef struct {
        logic        regwr;
        logic [4:0]  wsel;
        logic [31:0] wdat;
    } wb_exp_t;

    instr_t      stim_q[$];
    wb_exp_t     wb_q[$];
    logic [31:0] rd_q[$];
    logic [31:0] ref_mem[16];
    logic [31:0] cache_mem[16];

    int total = 0;
    int bad   = 0;
    bit en_s, flush_s, s_req, s_sel, busy, rand_stall, last_stall;
    int cnt, force_lat, force_stall;

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic instr_t make_nop();
        instr_t i;
        i = '{default: '0};
        return i;
    endfunction

    task automatic load_latch(input instr_t i);
        ex_valid = i.valid;  ex_regwr = i.regwr;  ex_dren = i.dren;   ex_dwen = i.dwen;
        ex_zero = i.zero;    ex_halt = i.hlt;     ex_aluout = i.aluout; ex_rdat2 = i.rdat2;
        ex_imm = i.imm;      ex_pc4 = i.pc4;      ex_jaddr = i.jaddr;  ex_baddr = i.baddr;
        ex_wsel = i.wsel;    ex_memtoreg = i.memtoreg; ex_pcsrc = i.pcsrc;
    endtask

    // Instruction-level reference: what this instruction must eventually
    // produce on the write-back bundle and on the redirect port.
    task automatic issue(input instr_t i);
        wb_exp_t e;
        logic [3:0] idx;
        if (!i.valid) return;
        idx = i.aluout[5:2];
        if (i.dwen && !i.dren) ref_mem[idx] = i.rdat2;
        if (i.pcsrc == PC_BR && i.zero) rd_q.push_back(i.baddr);
        if (i.pcsrc == PC_J)            rd_q.push_back(i.jaddr);
        if (i.pcsrc == PC_JR)           rd_q.push_back(i.aluout);
        if (!i.hlt) begin
            e.regwr = i.regwr;
            e.wsel  = i.wsel;
            case (i.memtoreg)
                WB_ALU:  e.wdat = i.aluout;
                WB_MEM:  e.wdat = ref_mem[idx];
                WB_PC4:  e.wdat = i.pc4;
                default: e.wdat = i.imm;
            endcase
            wb_q.push_back(e);
        end
    endtask

    // Data cache responder: a request completes after 0..3 extra cycles.
    task automatic cache_eval();
        logic [3:0] idx;
        dbus.dhit = 1'b0;
        if (!nRST) begin
            busy = 1'b0;
            return;
        end
        if (dbus.dmemREN || dbus.dmemWEN) begin
            idx = dbus.dmemaddr[5:2];
            if (!busy) begin
                busy = 1'b1;
                cnt  = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 3));
            end
            if (cnt == 0) begin
                busy = 1'b0;
                dbus.dhit = 1'b1;
                if (dbus.dmemREN) dbus.dmemload = cache_mem[idx];
                else begin
                    cache_mem[idx] = dbus.dmemstore;
                    dbus.dmemload  = $urandom;
                end
            end else cnt--;
        end
    endtask

    // One clock: the EX/MEM latch model advances on exmem_en (bubble on flush).
    task automatic step();
        instr_t cur;
        @(posedge CLK); #1;
        if (en_s) begin
            if (flush_s || stim_q.size() == 0) load_latch(make_nop());
            else begin
                cur = stim_q.pop_front();
                load_latch(cur);
                issue(cur);
            end
        end
        if (force_stall > 0) begin
            ext_stall = 1'b1;
            force_stall--;
        end else ext_stall = rand_stall ? ($urandom_range(0, 3) == 0) : 1'b0;
        #1; cache_eval();
        #1;
        en_s = exmem_en; flush_s = pipe_flush;
        s_req = dbus.dmemREN | dbus.dmemWEN; s_sel = npc_sel;
    endtask

    function automatic instr_t rand_instr();
        instr_t i;
        int m;
        i = make_nop();
        i.valid = 1'b1; i.aluout = $urandom; i.rdat2 = $urandom; i.imm = $urandom;
        i.pc4 = $urandom; i.jaddr = $urandom; i.baddr = $urandom;
        i.wsel = 5'($urandom); i.zero = 1'($urandom); i.regwr = 1'($urandom);
        m = $urandom_range(0, 2);
        i.memtoreg = (m == 0) ? WB_ALU : (m == 1) ? WB_PC4 : WB_IMM;
        case ($urandom_range(0, 5))
            1: begin i.dren = 1'b1; i.memtoreg = WB_MEM; end
            2: begin i.dwen = 1'b1; i.regwr = 1'b0; end
            3: i.pcsrc = PC_BR;
            4: i.pcsrc = $urandom_range(0, 1) ? PC_J : PC_JR;
            5: i.valid = 1'b0;
            default: ;
        endcase
        return i;
    endfunction

    task automatic directed(input instr_t i, input int lat, input int stl,
                            input int exp_req, input int exp_en0, input int exp_sel,
                            input string name);
        int nreq = 0, nen0 = 0, nsel = 0;
        stim_q.push_back(i);
        force_lat = lat; force_stall = stl;
        for (int k = 0; k < 8; k++) begin
            step();
            if (s_req) nreq++;
            if (!en_s) nen0++;
            if (s_sel) nsel++;
        end
        force_lat = -1;
        check_eq({name, "_req_cycles"}, 32'(nreq), 32'(exp_req));
        check_eq({name, "_stall_cycles"}, 32'(nen0), 32'(exp_en0));
        check_eq({name, "_redirect_cycles"}, 32'(nsel), 32'(exp_sel));
    endtask

    // Scoreboard monitor: a new bundle appears when wb_valid is high after an
    // edge that was not held by ext_stall.
    always @(negedge CLK) begin
        wb_exp_t e;
        if (nRST) begin
            if (wb_valid && !last_stall) begin
                if (wb_q.size() == 0) check_eq("wb_unexpected", 32'(wb_q.size()), 32'd1);
                else begin
                    e = wb_q.pop_front();
                    check_eq("wb_regwr", 32'(wb_regwr), 32'(e.regwr));
                    check_eq("wb_wsel", 32'(wb_wsel), 32'(e.wsel));
                    check_eq("wb_wdat", wb_wdat, e.wdat);
                end
            end
            if (npc_sel) begin
                if (rd_q.size() == 0) check_eq("redirect_unexpected", 32'(rd_q.size()), 32'd1);
                else check_eq("npc", npc, rd_q.pop_front());
                check_eq("pipe_flush", 32'(pipe_flush), 32'd1);
            end else check_eq("npc_idle", npc | 32'(pipe_flush), 32'd0);
        end
        last_stall = ext_stall;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        instr_t i;
        int n;
        force_lat = -1; force_stall = 0; rand_stall = 1'b0; busy = 1'b0;
        last_stall = 1'b0; ext_stall = 1'b0;
        for (int k = 0; k < 16; k++) begin
            ref_mem[k]   = $urandom;
            cache_mem[k] = ref_mem[k];
        end

        // Reset: a live load/jr/halt in the latch must not leak out.
        i = make_nop();
        i.valid = 1'b1; i.dren = 1'b1; i.hlt = 1'b1; i.aluout = 32'h44; i.pcsrc = PC_JR;
        load_latch(i);
        dbus.dhit = 1'b1; dbus.dmemload = 32'hFFFF_FFFF;
        #23;
        check_eq("rst_dmemREN", 32'(dbus.dmemREN), 32'd0);
        check_eq("rst_dmemWEN", 32'(dbus.dmemWEN), 32'd0);
        check_eq("rst_dmemaddr", dbus.dmemaddr, 32'd0);
        check_eq("rst_exmem_en", 32'(exmem_en), 32'd0);
        check_eq("rst_npc_sel", 32'(npc_sel), 32'd0);
        check_eq("rst_wb_valid", 32'(wb_valid), 32'd0);
        check_eq("rst_wb_wdat", wb_wdat, 32'd0);
        check_eq("rst_halt", 32'(halt), 32'd0);
        load_latch(make_nop()); dbus.dhit = 1'b0;
        @(negedge CLK); #1 nRST = 1'b1;
        en_s = 1'b1; flush_s = 1'b0;

        // Reset while a load is waiting on the cache.
        i = make_nop();
        i.valid = 1'b1; i.dren = 1'b1; i.aluout = 32'h8; i.memtoreg = WB_MEM; i.regwr = 1'b1;
        stim_q.push_back(i); force_lat = 10;
        for (int k = 0; k < 3; k++) step();
        check_eq("wait_req", 32'(s_req), 32'd1);
        #1 nRST = 1'b0;
        #1;
        check_eq("wait_rst_dmemREN", 32'(dbus.dmemREN), 32'd0);
        check_eq("wait_rst_wb_valid", 32'(wb_valid), 32'd0);
        check_eq("wait_rst_wb_regwr", 32'(wb_regwr), 32'd0);
        wb_q.delete(); rd_q.delete(); stim_q.delete();
        busy = 1'b0; force_lat = -1; dbus.dhit = 1'b0;
        load_latch(make_nop());
        @(negedge CLK); #1 nRST = 1'b1;
        en_s = 1'b1; flush_s = 1'b0;

        // Directed cases.
        ref_mem[0] = 32'hDEAD_BEEF; cache_mem[0] = 32'hDEAD_BEEF;
        i = make_nop(); i.valid = 1'b1; i.dren = 1'b1; i.aluout = 32'h100;
        i.memtoreg = WB_MEM; i.wsel = 5'd5; i.regwr = 1'b1;
        directed(i, 2, 0, 3, 2, 0, "load_lat3");
        i = make_nop(); i.valid = 1'b1; i.dwen = 1'b1; i.aluout = 32'h24; i.rdat2 = 32'h1234;
        directed(i, 0, 0, 1, 0, 0, "store_hit");
        i = make_nop(); i.valid = 1'b1; i.pcsrc = PC_BR; i.zero = 1'b1; i.baddr = 32'h40;
        i.aluout = 32'h77;
        directed(i, -1, 0, 0, 0, 1, "branch_taken");
        i.zero = 1'b0;
        directed(i, -1, 0, 0, 0, 0, "branch_not_taken");
        i = make_nop(); i.valid = 1'b1; i.pcsrc = PC_JR; i.aluout = 32'h1000; i.regwr = 1'b1;
        i.wsel = 5'd31;
        directed(i, -1, 0, 0, 0, 1, "jr");
        i = make_nop(); i.valid = 1'b1; i.dren = 1'b1; i.aluout = 32'h24;
        i.memtoreg = WB_MEM; i.wsel = 5'd9; i.regwr = 1'b1;
        directed(i, 0, 2, 1, 2, 0, "load_hit_stalled");

        // Randomized traffic with random downstream stalls and cache latency.
        for (int k = 0; k < 250; k++) stim_q.push_back(rand_instr());
        rand_stall = 1'b1;
        n = 0;
        while (stim_q.size() != 0 && n < 4000) begin
            step();
            n++;
        end
        check_eq("stim_drain", 32'(stim_q.size()), 32'd0);
        rand_stall = 1'b0;
        for (int k = 0; k < 12; k++) step();
        check_eq("wb_drain", 32'(wb_q.size()), 32'd0);

        // Halting jal: redirect once, no write-back, then frozen.
        i = make_nop(); i.valid = 1'b1; i.hlt = 1'b1; i.pcsrc = PC_J; i.jaddr = 32'h200;
        i.memtoreg = WB_PC4; i.pc4 = 32'h20; i.regwr = 1'b1; i.wsel = 5'd31;
        stim_q.push_back(i);
        n = 0;
        while (!halt && n < 10) begin
            step();
            n++;
        end
        check_eq("halt_set", 32'(halt), 32'd1);
        i = make_nop(); i.valid = 1'b1; i.dren = 1'b1; i.aluout = 32'h4;
        load_latch(i);
        for (int k = 0; k < 4; k++) begin
            step();
            check_eq("halt_no_req", 32'(s_req), 32'd0);
            check_eq("halt_exmem_en", 32'(exmem_en), 32'd0);
            check_eq("halt_wb_valid", 32'(wb_valid), 32'd0);
            check_eq("halt_sticky", 32'(halt), 32'd1);
        end
        check_eq("wb_queue_empty", 32'(wb_q.size()), 32'd0);
        check_eq("redirect_queue_empty", 32'(rd_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
